// File: rtl/block_state_loader.sv
// Streaming 128-bit block assembler: WORD_W-bit beats in, four 32-bit column words out,
// double-buffered. Optional in_last framing check enabled by BLOCK_STATE_FRAMING_EN.
module block_state_loader #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       word0,
    output logic [31:0]       word1,
    output logic [31:0]       word2,
    output logic [31:0]       word3,
    output logic              frame_err
);

    localparam int unsigned NBEATS = 128 / WORD_W;
    localparam int unsigned CntW   = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic [127:0]    asm_q, asm_d;
    logic [127:0]    out_q, out_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            asm_full_q, asm_full_d;
    logic            out_valid_q, out_valid_d;
    logic            frame_err_q, frame_err_d;

    logic            accept, is_final, out_take, viol, complete;
    logic [127:0]    blk;

    assign in_ready = !rst && !asm_full_q;
    assign accept   = in_valid && in_ready;
    assign is_final = (cnt_q == CntW'(NBEATS - 1));
    assign out_take = out_valid_q && out_ready;

`ifdef BLOCK_STATE_FRAMING_EN
    assign viol = accept && (in_last != is_final);
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign viol = 1'b0;
`endif

    assign complete = accept && is_final && !viol;

    // Assembly register with the current beat merged in
    always_comb begin
        blk = asm_q;
        blk[127 - WORD_W * int'(cnt_q) -: WORD_W] = in_data;
    end

    always_comb begin
        asm_d       = asm_q;
        out_d       = out_q;
        cnt_d       = cnt_q;
        asm_full_d  = asm_full_q;
        out_valid_d = out_valid_q;
        frame_err_d = viol;

        if (accept) begin
            asm_d = blk;
            if (viol || is_final) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (asm_full_q && out_take) begin
            // Pending block promotes; out_valid stays high
            out_d      = asm_q;
            asm_full_d = 1'b0;
        end else if (complete) begin
            if (!out_valid_q || out_take) begin
                out_d       = blk;
                out_valid_d = 1'b1;
            end else begin
                asm_full_d = 1'b1;
            end
        end else if (out_take) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q       <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            asm_full_q  <= 1'b0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            asm_full_q  <= asm_full_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign word0     = out_q[127:96];
    assign word1     = out_q[95:64];
    assign word2     = out_q[63:32];
    assign word3     = out_q[31:0];

`ifdef BLOCK_STATE_FRAMING_EN
    assign frame_err = frame_err_q;
`else
    logic unused_frame_err;
    assign unused_frame_err = frame_err_q;
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_block_state_loader.sv
// Directed self-checking bench for block_state_loader (32-bit and 8-bit beat instances).
module tb_block_state_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v32 = 1'b0, last32 = 1'b0, or32 = 1'b0;
    logic [31:0] d32 = '0;
    logic        rdy32, ov32, fe32;
    logic [31:0] w0, w1, w2, w3;

    logic        v8 = 1'b0, last8 = 1'b0, or8 = 1'b1;
    logic [7:0]  d8 = '0;
    logic        rdy8, ov8, fe8;
    logic [31:0] x0, x1, x2, x3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    block_state_loader #(.WORD_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .in_data(d32),
        .in_last(last32), .out_valid(ov32), .out_ready(or32),
        .word0(w0), .word1(w1), .word2(w2), .word3(w3), .frame_err(fe32)
    );

    block_state_loader #(.WORD_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
        .in_last(last8), .out_valid(ov8), .out_ready(or8),
        .word0(x0), .word1(x1), .word2(x2), .word3(x3), .frame_err(fe8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [31:0] d, input logic last);
        v32 = 1'b1; d32 = d; last32 = last;
        tick();
        v32 = 1'b0; last32 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (rdy32 !== 1'b0 || ov32 !== 1'b0 || fe32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rdy=%b ov=%b fe=%b, required 0 0 0", rdy32, ov32, fe32);
        end
        checks++;
        if ({w0, w1, w2, w3} !== 128'h0 || {x0, x1, x2, x3} !== 128'h0) begin
            errors++;
            $display("FAIL reset_words: got %h %h, required 0", {w0, w1, w2, w3}, {x0, x1, x2, x3});
        end
        rst = 1'b0;
        tick();
        checks++;
        if (rdy32 !== 1'b1 || rdy8 !== 1'b1 || ov32 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy32=%b rdy8=%b ov=%b, required 1 1 0", rdy32, rdy8, ov32);
        end
    endtask

    task automatic test_basic();
        or32 = 1'b1;
        send32(32'h00112233, 1'b0);
        send32(32'h44556677, 1'b0);
        send32(32'h8899AABB, 1'b0);
        checks++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: out_valid=%b, required 0", ov32);
        end
        send32(32'hCCDDEEFF, 1'b1);
        checks++;
        if (ov32 !== 1'b1 || {w0, w1, w2, w3} !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
            errors++;
            $display("FAIL basic_block: ov=%b words=%h, required 1 00112233..CCDDEEFF",
                     ov32, {w0, w1, w2, w3});
        end
        tick();
        checks++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL basic_drop: out_valid=%b, required 0", ov32);
        end
    endtask

    task automatic test_bytes();
        for (int i = 0; i < 16; i++) begin
            v8 = 1'b1; d8 = 8'(i);
            tick();
        end
        v8 = 1'b0;
        checks++;
        if (ov8 !== 1'b1 || {x0, x1, x2, x3} !== 128'h00010203_04050607_08090A0B_0C0D0E0F) begin
            errors++;
            $display("FAIL bytes_block: ov=%b words=%h, required 1 000102..0F", ov8,
                     {x0, x1, x2, x3});
        end
    endtask

    task automatic test_backpressure();
        or32 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            send32(32'(i), i == 4 || i == 8);
        end
        checks++;
        if (rdy32 !== 1'b0 || ov32 !== 1'b1 || {w0, w1, w2, w3} !== 128'h1_00000002_00000003_00000004) begin
            errors++;
            $display("FAIL bp_full: rdy=%b ov=%b words=%h, required 0 1 1/2/3/4", rdy32, ov32,
                     {w0, w1, w2, w3});
        end
        tick();
        checks++;
        if (rdy32 !== 1'b0 || w0 !== 32'd1) begin
            errors++;
            $display("FAIL bp_hold: rdy=%b word0=%h, required 0 1", rdy32, w0);
        end
        or32 = 1'b1;
        tick();
        checks++;
        if (rdy32 !== 1'b1 || ov32 !== 1'b1 || {w0, w1, w2, w3} !== 128'h5_00000006_00000007_00000008) begin
            errors++;
            $display("FAIL bp_promote: rdy=%b ov=%b words=%h, required 1 1 5/6/7/8", rdy32, ov32,
                     {w0, w1, w2, w3});
        end
        tick();
        checks++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%b, required 0", ov32);
        end
    endtask

    task automatic test_simultaneous();
        or32 = 1'b0;
        for (int i = 0; i < 4; i++) send32(32'hC0 + 32'(i), i == 3);
        for (int i = 0; i < 3; i++) send32(32'hD0 + 32'(i), 1'b0);
        or32 = 1'b1;
        send32(32'hD3, 1'b1);
        checks++;
        if (ov32 !== 1'b1 || rdy32 !== 1'b1 || w0 !== 32'hD0 || w3 !== 32'hD3) begin
            errors++;
            $display("FAIL simul_replace: ov=%b rdy=%b w0=%h w3=%h, required 1 1 D0 D3", ov32,
                     rdy32, w0, w3);
        end
        tick();
        checks++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL simul_drain: out_valid=%b, required 0", ov32);
        end
    endtask

    task automatic test_reset_mid();
        send32(32'hDEAD0000, 1'b0);
        send32(32'hDEAD0001, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (rdy32 !== 1'b0 || ov32 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b ov=%b, required 0 0", rdy32, ov32);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({w0, w1, w2, w3} !== 128'h0 || fe32 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: words=%h fe=%b, required 0 0", {w0, w1, w2, w3}, fe32);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send32(32'h11 * 32'(i + 1), i == 3);
        checks++;
        if (ov32 !== 1'b1 || {w0, w1, w2, w3} !== 128'h11_00000022_00000033_00000044) begin
            errors++;
            $display("FAIL mid_clean: ov=%b words=%h, required 1 11/22/33/44", ov32,
                     {w0, w1, w2, w3});
        end
        tick();
    endtask

`ifdef BLOCK_STATE_FRAMING_EN
    task automatic test_framing();
        send32(32'hBAD0, 1'b0);
        send32(32'hBAD1, 1'b1);
        checks++;
        if (fe32 !== 1'b1 || ov32 !== 1'b0) begin
            errors++;
            $display("FAIL frame_pulse: fe=%b ov=%b, required 1 0", fe32, ov32);
        end
        tick();
        checks++;
        if (fe32 !== 1'b0 || ov32 !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: fe=%b ov=%b, required 0 0", fe32, ov32);
        end
        send32(32'h9, 1'b0);
        send32(32'hA, 1'b0);
        send32(32'hB, 1'b0);
        send32(32'hC, 1'b1);
        checks++;
        if (ov32 !== 1'b1 || fe32 !== 1'b0 || {w0, w1, w2, w3} !== 128'h9_0000000A_0000000B_0000000C) begin
            errors++;
            $display("FAIL frame_recover: ov=%b fe=%b words=%h, required 1 0 9/A/B/C", ov32, fe32,
                     {w0, w1, w2, w3});
        end
        tick();
        for (int i = 0; i < 4; i++) send32(32'hE0 + 32'(i), 1'b0);
        checks++;
        if (fe32 !== 1'b1 || ov32 !== 1'b0) begin
            errors++;
            $display("FAIL frame_missing_last: fe=%b ov=%b, required 1 0", fe32, ov32);
        end
        tick();
    endtask
`else
    task automatic test_no_framing();
        send32(32'hF0, 1'b0);
        send32(32'hF1, 1'b1);
        checks++;
        if (fe32 !== 1'b0 || ov32 !== 1'b0) begin
            errors++;
            $display("FAIL noframe_ignore: fe=%b ov=%b, required 0 0", fe32, ov32);
        end
        send32(32'hF2, 1'b0);
        send32(32'hF3, 1'b0);
        checks++;
        if (ov32 !== 1'b1 || fe32 !== 1'b0 || {w0, w1, w2, w3} !== 128'hF0_000000F1_000000F2_000000F3) begin
            errors++;
            $display("FAIL noframe_block: ov=%b fe=%b words=%h, required 1 0 F0/F1/F2/F3", ov32,
                     fe32, {w0, w1, w2, w3});
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bytes();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
`ifdef BLOCK_STATE_FRAMING_EN
        test_framing();
`else
        test_no_framing();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_state_loader.md
# block_state_loader

Streaming successor to the combinational block-to-state splitter. It accepts a 128-bit AES block as a sequence of narrower beats over a valid/ready handshake and assembles the beats into a state register. It presents the result as four 32-bit column words (word0..word3, word0 = most significant) with an output valid/ready handshake. It sits between the byte/word input interface and the cipher core, and double-buffers so the next block can load while the core holds the current one.

## Interface
- WORD_W, 32, input beat width; legal values 8, 16, 32, 64, 128 (must divide 128)
- NBEATS, 128/WORD_W, derived localparam, beats per block
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  WORD_W  beat payload; first beat is block bits [127:128-WORD_W]
- in_last  in  1  producer marks final beat of a block (checked only with framing feature)
- out_valid  out  1  assembled block available
- out_ready  in  1  consumer takes block
- word0..word3  out  32 each  state columns: word0 = block[127:96], word1 = [95:64], word2 = [63:32], word3 = [31:0]
- frame_err  out  1  one-cycle pulse on framing violation

## Operation
- Clock is clk; reset is rst, synchronous, active-high.
- Storage:
  - asm_q[127:0] assembly register; beat counter cnt in 0..NBEATS-1; flag asm_full.
  - Output register out_q[127:0] with out_valid.
- Beat accept when in_valid && in_ready: in_data is written to slice [127-WORD_W*cnt -: WORD_W] of asm_q.
- Non-final beat: cnt increments.
- Final beat (cnt == NBEATS-1):
  - cnt returns to 0.
  - If out_q is empty, or out_valid && out_ready in the same cycle, the completed block (including this beat) loads out_q next edge.
  - Otherwise asm_full is set.
- asm_full = 1: in_ready = 0. On the cycle out_valid && out_ready, asm_q moves to out_q, out_valid stays 1, and asm_full clears.
- in_ready = !rst && !asm_full.
- out_valid drops after a handshake only if no block is pending.
- word0..word3 are combinational slices of out_q. They are stable while out_valid && !out_ready.
- NBEATS = 1 (WORD_W = 128): every beat is final. The block degenerates to a 2-deep block buffer.

## Timing
- Reset values: out_valid 0, word0..word3 0, frame_err 0, in_ready 0 during reset and 1 on the first cycle after. cnt, asm_full, asm_q and out_q are cleared.
- Latency: final beat accepted at edge t gives out_valid = 1 after edge t, with the block visible in cycle t+1.
- Throughput: one beat per cycle sustained when out_ready is held 1. No bubbles between blocks.
- Backpressure: at most two blocks are held (out_q plus asm_q). in_ready falls the cycle after the final beat of the second block. It rises the cycle after the out handshake.
- Simultaneous final-beat accept and out handshake: the new block replaces out_q and out_valid stays 1.
- Reset mid-block: the partial block is discarded and the next accepted beat is beat 0.

## Configuration
- BLOCK_STATE_FRAMING_EN defined: in_last is checked on every accepted beat.
  - in_last = 1 with cnt != NBEATS-1 is a violation.
  - in_last = 0 with cnt == NBEATS-1 is a violation.
  - On a violation, frame_err pulses for exactly 1 cycle after the offending edge, the partial block is discarded, cnt returns to 0, and no out_valid is produced for that block.
  - The beat after the violation is treated as beat 0.
- Not defined: in_last is ignored, frame_err is tied 0, and a block completes purely on the count.

## Test plan
- WORD_W=32, out_ready=1, beats 00112233, 44556677, 8899AABB, CCDDEEFF (last on beat 4) -> out_valid 1 for one cycle after beat 4 edge; word0=00112233, word3=CCDDEEFF.
- WORD_W=8, 16 beats 0x00..0x0F back-to-back -> word0=00010203, word1=04050607, word2=08090A0B, word3=0C0D0E0F.
- WORD_W=32, out_ready=0, two blocks A (words 1,2,3,4) and B (words 5,6,7,8) fed -> in_ready 0 after B's 4th beat and words hold A. Raise out_ready -> A taken, next cycle word0=5, then out_valid 0.
- FRAMING_EN, in_last on beat 2 of 4 -> frame_err pulse of 1 cycle, no out_valid. Next 4 beats 9,A,B,C (last on 4th) -> word0=9..word3=C.
- Reset asserted for 1 cycle after 2 beats -> all outputs 0, in_ready 0 during reset. Following 4 beats form a clean block.
- FRAMING_EN undefined, in_last on beat 2 -> frame_err stays 0 and the block completes after beat 4.
